// File: rtl/pe_fifo_pkg.sv
// Shared types and constants for the PE-side FIFO read path.
package pe_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    // Fewest skid entries that still cover the 2-cycle read turnaround at 1 word/cycle.
    localparam int unsigned SKID_MIN = 3;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Circular skid buffer catching registered FIFO read data ahead of the stream port.
module rd_skid_buf
    import pe_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SKID  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [cnt_w(SKID)-1:0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned CNT_W = cnt_w(SKID);
    localparam int unsigned PTR_W = (SKID > 1) ? $clog2(SKID) : 1;

    logic [WIDTH-1:0] mem [SKID];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at SKID, so any depth works, not only powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push && (count != CNT_W'(SKID));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset; an empty buffer presents zero at the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Burst read controller: pops burst_len words from syn_fifo and streams them out valid/ready.
module fifo_rd_streamer
    import pe_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LEN_W = 6,
    parameter int unsigned SKID  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             burst_start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             burst_busy,
    output logic             burst_done,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready
);

    localparam int unsigned SKID_EFF = (SKID < SKID_MIN) ? SKID_MIN : SKID;
    localparam int unsigned CNT_W    = cnt_w(SKID_EFF);
    localparam int unsigned OCC_W    = CNT_W + 1;

    rd_state_e        state;
    rd_state_e        next_state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] beats_out;
    logic [LEN_W-1:0] last_idx;
    logic             inflight;
    logic             accept;
    logic             xfer;
    logic             last_xfer;
    logic             issue_left;
    logic             room;
    logic [CNT_W-1:0] buf_count;
    logic [WIDTH-1:0] head;

    assign accept     = (state == ST_IDLE) && burst_start;
    assign xfer       = m_valid && m_ready;
    assign last_xfer  = xfer && m_last;
    assign last_idx   = len_q - LEN_W'(1);
    assign issue_left = issued < len_q;
    // Reserve a slot for the word already requested so m_ready never reaches fifo_rd.
    assign room       = (OCC_W'(buf_count) + OCC_W'(inflight)) < OCC_W'(SKID_EFF);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (burst_start) next_state = (burst_len == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (!issue_left) next_state = last_xfer ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (last_xfer)   next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        burst_busy = 1'b0;
        burst_done = 1'b0;
        fifo_rd    = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;

        burst_busy = (state != ST_IDLE);
        burst_done = (state == ST_DONE);
        fifo_rd    = (state == ST_ISSUE) && !fifo_empty && issue_left && room;
        m_valid    = (buf_count != '0);
        m_data     = head;
        m_last     = m_valid && (beats_out == last_idx);
    end

    // Burst length latch, issue and transfer counters, read-data-pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            issued    <= '0;
            beats_out <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= fifo_rd;
            if (accept) begin
                len_q     <= burst_len;
                issued    <= '0;
                beats_out <= '0;
            end else begin
                if (fifo_rd) issued    <= issued + LEN_W'(1);
                if (xfer)    beats_out <= beats_out + LEN_W'(1);
            end
        end
    end

    rd_skid_buf #(
        .WIDTH (WIDTH),
        .SKID  (SKID_EFF)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (xfer),
        .count     (buf_count),
        .head      (head)
    );

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench for fifo_rd_streamer against a behavioural registered-output FIFO.
module tb_fifo_rd_streamer;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned LEN_W = 6;
    localparam int unsigned SKID  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             burst_start;
    logic [LEN_W-1:0] burst_len;
    logic             burst_busy;
    logic             burst_done;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [WIDTH-1:0] fifo_data;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             m_ready;

    always #5 clk = ~clk;

    fifo_rd_streamer #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W),
        .SKID  (SKID)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .burst_busy  (burst_busy),
        .burst_done  (burst_done),
        .fifo_empty  (fifo_empty),
        .fifo_rd     (fifo_rd),
        .fifo_data   (fifo_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
        int               cyc;
    } beat_t;

    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] sb_q[$];
    beat_t            beat_q[$];
    int               rd_q[$];
    int               done_q[$];
    int               busy_q[$];
    int               cyc;
    int               t0;
    int               n_tests;
    int               n_fail;
    int               hold_err;
    int               fifo_uflow;
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;
    logic [WIDTH-1:0] exp_w;
    bit               ok;

    // One clock: observe at negedge, then advance the FIFO model just after posedge.
    task automatic tick();
        logic  rd_now;
        beat_t b;
        @(negedge clk);
        rd_now = fifo_rd;
        if (!rst) begin
            if (fifo_rd)    rd_q.push_back(cyc);
            if (burst_done) done_q.push_back(cyc);
            if (burst_busy) busy_q.push_back(cyc);
            if (prev_stall && (!m_valid || m_data !== prev_data)) hold_err++;
            if (m_valid && m_ready) begin
                b.data = m_data;
                b.last = m_last;
                b.cyc  = cyc;
                beat_q.push_back(b);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rd_now === 1'b1) begin
            if (fq.size() == 0) fifo_uflow++;
            else                fifo_data = fq.pop_front();
        end
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic fifo_push(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        done_q.delete();
        busy_q.delete();
        beat_q.delete();
        sb_q.delete();
        hold_err   = 0;
        fifo_uflow = 0;
    endtask

    task automatic start_burst(input int len);
        burst_start = 1'b1;
        burst_len   = LEN_W'(len);
        t0          = cyc;
        tick();
        burst_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit done_ok);
        done_ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!burst_busy) begin
                done_ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({fifo_rd, m_valid, m_last, burst_busy, burst_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rd/valid/last/busy/done=%b, want 00000",
                     {fifo_rd, m_valid, m_last, burst_busy, burst_done});
        end
        n_tests++;
        if (m_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: m_data=%h, want 0", m_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            fifo_push(WIDTH'(8'h10 + i));
            sb_q.push_back(WIDTH'(8'h10 + i));
        end
        m_ready = 1'b1;
        start_burst(8);
        wait_idle(40, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: busy=%b, want 0", burst_busy); end
        n_tests++;
        if (rd_q.size() != 8) begin
            n_fail++;
            $display("FAIL basic_rd_count: got %0d reads, want 8", rd_q.size());
        end
        for (int i = 0; i < rd_q.size(); i++) begin
            n_tests++;
            if (rd_q[i] != t0 + 1 + i) begin
                n_fail++;
                $display("FAIL basic_rd_cyc[%0d]: got c%0d, want c%0d", i, rd_q[i] - t0, 1 + i);
            end
        end
        n_tests++;
        if (beat_q.size() != 8) begin
            n_fail++;
            $display("FAIL basic_beats: got %0d beats, want 8", beat_q.size());
        end
        for (int i = 0; i < beat_q.size(); i++) begin
            exp_w = '1;
            if (sb_q.size() != 0) exp_w = sb_q.pop_front();
            n_tests++;
            if (beat_q[i].data !== exp_w || beat_q[i].last !== (i == 7) || beat_q[i].cyc != t0 + 3 + i) begin
                n_fail++;
                $display("FAIL basic_beat[%0d]: data=%h last=%b c%0d, want data=%h last=%b c%0d",
                         i, beat_q[i].data, beat_q[i].last, beat_q[i].cyc - t0, exp_w, (i == 7), 3 + i);
            end
        end
        n_tests++;
        if (done_q.size() != 1 || done_q[0] != t0 + 11) begin
            n_fail++;
            $display("FAIL basic_done: %0d pulses first c%0d, want 1 pulse at c11",
                     done_q.size(), (done_q.size() != 0) ? done_q[0] - t0 : -1);
        end
    endtask

    task automatic test_backpressure();
        int early;
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            fifo_push(WIDTH'(8'h20 + i));
            sb_q.push_back(WIDTH'(8'h20 + i));
        end
        m_ready = 1'b0;
        start_burst(8);
        while (cyc < t0 + 10) tick();
        m_ready = 1'b1;
        wait_idle(40, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL stall_timeout: busy=%b, want 0", burst_busy); end
        early = 0;
        foreach (rd_q[i]) if (rd_q[i] < t0 + 11) early++;
        n_tests++;
        if (early != 3) begin
            n_fail++;
            $display("FAIL stall_rd_stop: got %0d reads before resume, want 3", early);
        end
        n_tests++;
        if (rd_q.size() != 8 || rd_q[3] != t0 + 11) begin
            n_fail++;
            $display("FAIL stall_rd_resume: %0d reads, 4th at c%0d, want 8 reads, 4th at c11",
                     rd_q.size(), (rd_q.size() > 3) ? rd_q[3] - t0 : -1);
        end
        n_tests++;
        if (beat_q.size() != 8 || beat_q[0].cyc != t0 + 10) begin
            n_fail++;
            $display("FAIL stall_beats: %0d beats, first at c%0d, want 8, first at c10",
                     beat_q.size(), (beat_q.size() != 0) ? beat_q[0].cyc - t0 : -1);
        end
        for (int i = 0; i < beat_q.size(); i++) begin
            exp_w = '1;
            if (sb_q.size() != 0) exp_w = sb_q.pop_front();
            n_tests++;
            if (beat_q[i].data !== exp_w || beat_q[i].last !== (i == 7)) begin
                n_fail++;
                $display("FAIL stall_beat[%0d]: data=%h last=%b, want data=%h last=%b",
                         i, beat_q[i].data, beat_q[i].last, exp_w, (i == 7));
            end
        end
        n_tests++;
        if (hold_err != 0 || fifo_uflow != 0) begin
            n_fail++;
            $display("FAIL stall_hold: hold_err=%0d uflow=%0d, want 0/0", hold_err, fifo_uflow);
        end
    endtask

    task automatic test_trickle();
        int pushed;
        clear_logs();
        pushed  = 0;
        m_ready = 1'b1;
        start_burst(4);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (pushed < 4 && cyc == t0 + 1 + 4 * pushed) begin
                fifo_push(WIDTH'(8'h30 + pushed));
                sb_q.push_back(WIDTH'(8'h30 + pushed));
                pushed++;
            end
            tick();
            if (!burst_busy) begin ok = 1'b1; break; end
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL trickle_timeout: busy=%b, want 0", burst_busy); end
        n_tests++;
        if (rd_q.size() != 4 || beat_q.size() != 4) begin
            n_fail++;
            $display("FAIL trickle_count: reads=%0d beats=%0d, want 4/4", rd_q.size(), beat_q.size());
        end
        for (int i = 0; i < beat_q.size() && i < rd_q.size(); i++) begin
            exp_w = '1;
            if (sb_q.size() != 0) exp_w = sb_q.pop_front();
            n_tests++;
            if (rd_q[i] != t0 + 1 + 4 * i || beat_q[i].cyc != rd_q[i] + 2 ||
                beat_q[i].data !== exp_w || beat_q[i].last !== (i == 3)) begin
                n_fail++;
                $display("FAIL trickle_beat[%0d]: rd c%0d beat c%0d data=%h last=%b, want rd c%0d beat c%0d data=%h last=%b",
                         i, rd_q[i] - t0, beat_q[i].cyc - t0, beat_q[i].data, beat_q[i].last,
                         1 + 4 * i, 3 + 4 * i, exp_w, (i == 3));
            end
        end
        n_tests++;
        if (done_q.size() != 1 || done_q[0] != t0 + 16 || fifo_uflow != 0) begin
            n_fail++;
            $display("FAIL trickle_done: %0d pulses first c%0d uflow=%0d, want 1 at c16 uflow 0",
                     done_q.size(), (done_q.size() != 0) ? done_q[0] - t0 : -1, fifo_uflow);
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        fifo_push(WIDTH'(8'h40));
        m_ready = 1'b1;
        start_burst(0);
        repeat (6) tick();
        n_tests++;
        if (rd_q.size() != 0 || beat_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_len_io: reads=%0d beats=%0d, want 0/0", rd_q.size(), beat_q.size());
        end
        n_tests++;
        if (done_q.size() != 1 || done_q[0] != t0 + 1) begin
            n_fail++;
            $display("FAIL zero_len_done: %0d pulses first c%0d, want 1 at c1",
                     done_q.size(), (done_q.size() != 0) ? done_q[0] - t0 : -1);
        end
        n_tests++;
        if (busy_q.size() != 1 || busy_q[0] != t0 + 1) begin
            n_fail++;
            $display("FAIL zero_len_busy: %0d busy cycles first c%0d, want busy through c1 only",
                     busy_q.size(), (busy_q.size() != 0) ? busy_q[0] - t0 : -1);
        end
        void'(fq.pop_front());
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic test_reset_mid();
        clear_logs();
        for (int i = 0; i < 6; i++) fifo_push(WIDTH'(8'h50 + i));
        m_ready = 1'b0;
        start_burst(2);
        while (cyc < t0 + 5) tick();
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== WIDTH'(8'h50) || burst_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: valid=%b data=%h busy=%b, want 1/50/1", m_valid, m_data, burst_busy);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (m_valid !== 1'b0 || burst_busy !== 1'b0 || m_data !== '0) begin
            n_fail++;
            $display("FAIL rstmid_post: valid=%b busy=%b data=%h, want 0/0/0", m_valid, burst_busy, m_data);
        end
        rst = 1'b0;
        clear_logs();
        sb_q.push_back(WIDTH'(8'h52));
        sb_q.push_back(WIDTH'(8'h53));
        m_ready = 1'b1;
        start_burst(2);
        wait_idle(30, ok);
        n_tests++;
        if (!ok || beat_q.size() != 2) begin
            n_fail++;
            $display("FAIL rstmid_burst: done=%b beats=%0d, want 1/2", ok, beat_q.size());
        end
        for (int i = 0; i < beat_q.size(); i++) begin
            exp_w = '1;
            if (sb_q.size() != 0) exp_w = sb_q.pop_front();
            n_tests++;
            if (beat_q[i].data !== exp_w || beat_q[i].last !== (i == 1)) begin
                n_fail++;
                $display("FAIL rstmid_beat[%0d]: data=%h last=%b, want data=%h last=%b",
                         i, beat_q[i].data, beat_q[i].last, exp_w, (i == 1));
            end
        end
        n_tests++;
        if (fq.size() != 2) begin
            n_fail++;
            $display("FAIL rstmid_fifo_left: got %0d words, want 2", fq.size());
        end
    endtask

    task automatic test_start_while_busy();
        clear_logs();
        for (int i = 0; i < 8; i++) fifo_push(WIDTH'(8'h60 + i));
        sb_q.push_back(WIDTH'(8'h54));
        sb_q.push_back(WIDTH'(8'h55));
        sb_q.push_back(WIDTH'(8'h60));
        m_ready = 1'b1;
        start_burst(3);
        burst_start = 1'b1;
        burst_len   = LEN_W'(5);
        tick();
        burst_start = 1'b0;
        wait_idle(30, ok);
        repeat (6) tick();
        n_tests++;
        if (!ok || burst_busy !== 1'b0 || done_q.size() != 1) begin
            n_fail++;
            $display("FAIL busy_ign_state: done=%b busy=%b pulses=%0d, want 1/0/1", ok, burst_busy, done_q.size());
        end
        n_tests++;
        if (rd_q.size() != 3 || beat_q.size() != 3 || fq.size() != 7) begin
            n_fail++;
            $display("FAIL busy_ign_count: reads=%0d beats=%0d fifo_left=%0d, want 3/3/7",
                     rd_q.size(), beat_q.size(), fq.size());
        end
        for (int i = 0; i < beat_q.size(); i++) begin
            exp_w = '1;
            if (sb_q.size() != 0) exp_w = sb_q.pop_front();
            n_tests++;
            if (beat_q[i].data !== exp_w || beat_q[i].last !== (i == 2)) begin
                n_fail++;
                $display("FAIL busy_ign_beat[%0d]: data=%h last=%b, want data=%h last=%b",
                         i, beat_q[i].data, beat_q[i].last, exp_w, (i == 2));
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        burst_start = 1'b0;
        burst_len   = '0;
        fifo_empty  = 1'b1;
        fifo_data   = '0;
        m_ready     = 1'b0;
        cyc         = 0;
        t0          = 0;
        n_tests     = 0;
        n_fail      = 0;
        hold_err    = 0;
        fifo_uflow  = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_trickle();
        test_zero_len();
        test_reset_mid();
        test_start_while_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1);
    end

endmodule
